bulk_ep_in_packetiser: RTL and testbench
========================================

// Module: bulk_ep_in_packetiser
// PURPOSE
//  USB bulk IN endpoint buffer: accepts a user AXI-Stream byte stream and packetises it into
//  packets of at most MAX_PACKET bytes for the USB protocol core. It signals packet
//  availability, streams one packet per IN transaction and holds that packet until the
//  transaction is ACKed. An aborted transaction rewinds the packet so it can be retransmitted.
//  Single clock domain; it sits between user logic and the USB core's bulk IN endpoint port.
// PARAMETERS
//  ABITS       11   log2 of buffer depth in bytes; 2**ABITS must be >= 2*MAX_PACKET
//  MAX_PACKET  512  max bytes per USB packet (512 HS, 64 FS)
// PORTS
//  bulk_ep_in_clock          in   1  sole clock (USB core clock)
//  reset_n                   in   1  asynchronous, active-low reset
//  axis_tvalid_i             in   1  user stream valid
//  axis_tready_o             out  1  user stream ready
//  axis_tlast_i              in   1  user end-of-transfer; closes the current packet
//  axis_tdata_i              in   8  user byte
//  bulk_ep_in_ready_write_o  out  1  >=1 complete packet buffered and no packet in flight
//  bulk_ep_in_xfer_i         in   1  1-cycle pulse: core starts IN data phase
//  bulk_ep_in_ack_i          in   1  1-cycle pulse: host ACKed; drop the in-flight packet
//  bulk_ep_in_abort_i        in   1  1-cycle pulse: timeout/no ACK; rewind the in-flight packet
//  bulk_ep_in_tvalid_o       out  1  packet byte valid to core
//  bulk_ep_in_tready_i       in   1  core accepts byte
//  bulk_ep_in_tlast_o        out  1  final byte of the packet
//  bulk_ep_in_tdata_o        out  8  packet byte
// BEHAVIOUR
//  - Reset (async assert, sync deassert):
//    - pointers, counters and pkt_count = 0; state = IDLE.
//    - All outputs 0, including axis_tready_o and bulk_ep_in_ready_write_o.
//  - Buffer: 2**ABITS x 9 bits {boundary, data}. Three ABITS+1 pointers:
//    - wr_ptr: write pointer.
//    - rd_ptr: speculative read pointer.
//    - cm_ptr: committed read pointer.
//  - Full/empty:
//    - full  = (wr_ptr - cm_ptr) == 2**ABITS.
//    - axis_tready_o = !full (registered, so it takes effect the cycle after full).
//  - Write side:
//    - wr_cnt counts bytes in the open packet.
//    - The boundary bit is set on the accepted byte when axis_tlast_i=1 or wr_cnt==MAX_PACKET-1.
//    - That byte closes the packet: pkt_count++ and wr_cnt=0.
//    - Because of the boundary rule, a 513-byte transfer with MAX_PACKET=512 gives packets of 512 and 1 bytes.
//    - No zero-length packets are generated.
//  - pkt_count: ABITS+1 bits.
//    - Incremented on packet close, decremented on ack.
//    - Simultaneous increment and decrement leaves it unchanged.
//  - bulk_ep_in_ready_write_o is registered: (pkt_count!=0) && state==IDLE.
//  - FSM IDLE -> SEND -> WAIT_ACK -> IDLE:
//    - IDLE: on xfer_i with pkt_count!=0 -> SEND. An xfer_i with pkt_count==0 is ignored.
//    - SEND: tvalid_o=1, first byte the cycle after xfer_i (first-word fall-through).
//      - tdata/tlast come from buffer[rd_ptr]; tlast_o = boundary bit.
//      - On tvalid&tready, rd_ptr++. If tlast_o, -> WAIT_ACK.
//      - Outputs stay stable while tready_i=0.
//    - WAIT_ACK: on ack_i, cm_ptr<=rd_ptr, pkt_count--, -> IDLE.
//    - abort_i in SEND or WAIT_ACK: rd_ptr<=cm_ptr, -> IDLE; the packet stays counted and is resent.
//    - Simultaneous ack_i and abort_i: abort wins.
//    - ack_i in SEND or in IDLE is ignored.
//  - Writes continue during SEND/WAIT_ACK. Space is freed only at commit, so an in-flight
//    packet is never overwritten.
//  - Pointer wrap is natural modulo 2**(ABITS+1) arithmetic; a packet may straddle the buffer end.
//  - Throughput: 1 byte/clk on each side concurrently.
// STRUCTURE
//  - Shared package usb_pkg: MAX_PACKET_HS=512, MAX_PACKET_FS=64; FSM state encoding ep_in_state_t.
//  - One sub-module: sync_ram_dp (ABITS x 9, one write port, one async/read-ahead read port).
//  - Pointer, counter and FSM logic live in this module.
// TESTING
//  - 1: reset, 4-byte transfer with tlast.
//    -> ready_write rises; xfer_i gives 4 beats with tlast on beat 4; ack_i drops ready_write.
//  - 2: 1025 bytes, MAX_PACKET=512.
//    -> three packets of 512, 512 and 1 bytes; tlast on each packet end; data matches the input.
//  - 3: xfer_i, abort_i after 100 beats.
//    -> ready_write returns; the next xfer_i resends the same packet from byte 0; ack_i then commits it.
//  - 4: fill buffer with no ack.
//    -> axis_tready_o=0 after 2048 bytes; one ack of a 512-byte packet re-enables exactly 512 writes.
//  - 5: tready_i toggles randomly during SEND.
//    -> tdata/tlast stable while stalled; no byte lost or duplicated.
//  - 6: reset_n asserted mid-SEND with 2 packets pending.
//    -> all outputs 0 immediately; after release ready_write=0 and the buffer is empty.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB constants and bulk IN endpoint state encoding
// Purpose: packet size limits for high/full speed and the bulk IN FSM state type.
// Ports: none (package).
package usb_pkg;

  localparam int MAX_PACKET_HS = 512;
  localparam int MAX_PACKET_FS = 64;

  typedef enum logic [1:0] {
    EP_IN_IDLE     = 2'd0,
    EP_IN_SEND     = 2'd1,
    EP_IN_WAIT_ACK = 2'd2
  } ep_in_state_t;

endpackage

// File: rtl/sync_ram_dp.sv
// rtl/sync_ram_dp.sv - simple dual-port RAM, synchronous write, read-ahead read
// Purpose: packet byte store for the bulk IN endpoint.
// Ports:
//   clock  in  write clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write word
//   raddr  in  read address
//   rdata  out word at raddr, valid in the same cycle (fall-through)
module sync_ram_dp #(
  parameter int ABITS = 11,
  parameter int DBITS = 9
) (
  input  logic             clock,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdata
);

  logic [DBITS-1:0] mem [2**ABITS];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bulk_ep_in_packetiser.sv
// rtl/bulk_ep_in_packetiser.sv - USB bulk IN endpoint buffer and packetiser
// Purpose: buffers a user byte stream, cuts it into packets of at most MAX_PACKET
// bytes, streams one packet per IN transaction and keeps it until ACKed; an abort
// rewinds the packet for retransmission.
// Ports:
//   bulk_ep_in_clock          in   sole clock
//   reset_n                   in   asynchronous active-low reset
//   axis_tvalid_i/tready_o/tlast_i/tdata_i   user byte stream in
//   bulk_ep_in_ready_write_o  out  complete packet buffered, none in flight
//   bulk_ep_in_xfer_i         in   pulse: start IN data phase
//   bulk_ep_in_ack_i          in   pulse: host ACKed the in-flight packet
//   bulk_ep_in_abort_i        in   pulse: no ACK, rewind the in-flight packet
//   bulk_ep_in_tvalid_o/tready_i/tlast_o/tdata_o  packet byte stream out
module bulk_ep_in_packetiser
  import usb_pkg::*;
#(
  parameter int ABITS      = 11,
  parameter int MAX_PACKET = MAX_PACKET_HS
) (
  input  logic       bulk_ep_in_clock,
  input  logic       reset_n,
  input  logic       axis_tvalid_i,
  output logic       axis_tready_o,
  input  logic       axis_tlast_i,
  input  logic [7:0] axis_tdata_i,
  output logic       bulk_ep_in_ready_write_o,
  input  logic       bulk_ep_in_xfer_i,
  input  logic       bulk_ep_in_ack_i,
  input  logic       bulk_ep_in_abort_i,
  output logic       bulk_ep_in_tvalid_o,
  input  logic       bulk_ep_in_tready_i,
  output logic       bulk_ep_in_tlast_o,
  output logic [7:0] bulk_ep_in_tdata_o
);

  localparam int PW = ABITS + 1;
  localparam logic [PW-1:0] DEPTH    = PW'(2**ABITS);
  localparam logic [PW-1:0] LAST_IDX = PW'(MAX_PACKET - 1);

  ep_in_state_t  state;
  logic [PW-1:0] wr_ptr, rd_ptr, cm_ptr, wr_cnt, pkt_count;
  logic [PW-1:0] wr_ptr_nx, cm_ptr_nx, pkt_count_nx;
  logic [8:0]    rd_word;
  logic          wr_fire, wr_boundary, pkt_close, rd_fire;
  logic          do_start, do_abort, do_commit, idle_nx;

  assign wr_fire     = axis_tvalid_i && axis_tready_o;
  assign wr_boundary = axis_tlast_i || (wr_cnt == LAST_IDX);
  assign pkt_close   = wr_fire && wr_boundary;
  assign rd_fire     = bulk_ep_in_tvalid_o && bulk_ep_in_tready_i;

  assign do_start  = (state == EP_IN_IDLE) && bulk_ep_in_xfer_i && (pkt_count != '0);
  assign do_abort  = (state != EP_IN_IDLE) && bulk_ep_in_abort_i;
  // Abort takes priority over a coincident ack.
  assign do_commit = (state == EP_IN_WAIT_ACK) && bulk_ep_in_ack_i && !bulk_ep_in_abort_i;
  assign idle_nx   = ((state == EP_IN_IDLE) && !do_start) || do_abort || do_commit;

  // Next-cycle values feed the registered flags so they never lag the pointers.
  assign wr_ptr_nx    = wr_ptr + PW'(wr_fire);
  assign cm_ptr_nx    = do_commit ? rd_ptr : cm_ptr;
  assign pkt_count_nx = pkt_count + PW'(pkt_close) - PW'(do_commit);

  sync_ram_dp #(.ABITS(ABITS), .DBITS(9)) u_ram (
    .clock (bulk_ep_in_clock),
    .we    (wr_fire),
    .waddr (wr_ptr[ABITS-1:0]),
    .wdata ({wr_boundary, axis_tdata_i}),
    .raddr (rd_ptr[ABITS-1:0]),
    .rdata (rd_word)
  );

  // Data lines are forced low whenever nothing is being presented.
  assign bulk_ep_in_tvalid_o = (state == EP_IN_SEND);
  assign bulk_ep_in_tlast_o  = bulk_ep_in_tvalid_o && rd_word[8];
  assign bulk_ep_in_tdata_o  = bulk_ep_in_tvalid_o ? rd_word[7:0] : 8'h00;

  always_ff @(posedge bulk_ep_in_clock or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= EP_IN_IDLE;
      wr_ptr                   <= '0;
      rd_ptr                   <= '0;
      cm_ptr                   <= '0;
      wr_cnt                   <= '0;
      pkt_count                <= '0;
      axis_tready_o            <= 1'b0;
      bulk_ep_in_ready_write_o <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nx;
      cm_ptr    <= cm_ptr_nx;
      pkt_count <= pkt_count_nx;
      if (wr_fire) wr_cnt <= pkt_close ? '0 : wr_cnt + 1'b1;
      // Space only returns on commit, so an in-flight packet is never overwritten.
      axis_tready_o            <= (wr_ptr_nx - cm_ptr_nx) != DEPTH;
      bulk_ep_in_ready_write_o <= idle_nx && (pkt_count_nx != '0);

      case (state)
        EP_IN_IDLE: begin
          if (do_start) state <= EP_IN_SEND;
        end
        EP_IN_SEND: begin
          if (do_abort) begin
            rd_ptr <= cm_ptr;
            state  <= EP_IN_IDLE;
          end else if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (bulk_ep_in_tlast_o) state <= EP_IN_WAIT_ACK;
          end
        end
        EP_IN_WAIT_ACK: begin
          if (do_abort) begin
            rd_ptr <= cm_ptr;
            state  <= EP_IN_IDLE;
          end else if (do_commit) begin
            state <= EP_IN_IDLE;
          end
        end
        default: state <= EP_IN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bulk_ep_in_packetiser.sv
// tb/tb_bulk_ep_in_packetiser.sv - scoreboard bench for the bulk IN packetiser
module tb_bulk_ep_in_packetiser;

  localparam int MAXP = 512;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       axis_tvalid = 1'b0;
  logic       axis_tready;
  logic       axis_tlast = 1'b0;
  logic [7:0] axis_tdata = 8'h00;
  logic       ready_write;
  logic       xfer = 1'b0;
  logic       ack = 1'b0;
  logic       abort = 1'b0;
  logic       ep_tvalid;
  logic       ep_tready = 1'b0;
  logic       ep_tlast;
  logic [7:0] ep_tdata;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic [8:0] buf_q[$];
  int model_wr_cnt = 0;
  int wr_seq = 0;
  int acc;

  always #5 clk = ~clk;

  bulk_ep_in_packetiser #(.ABITS(11), .MAX_PACKET(MAXP)) dut (
    .bulk_ep_in_clock         (clk),
    .reset_n                  (reset_n),
    .axis_tvalid_i            (axis_tvalid),
    .axis_tready_o            (axis_tready),
    .axis_tlast_i             (axis_tlast),
    .axis_tdata_i             (axis_tdata),
    .bulk_ep_in_ready_write_o (ready_write),
    .bulk_ep_in_xfer_i        (xfer),
    .bulk_ep_in_ack_i         (ack),
    .bulk_ep_in_abort_i       (abort),
    .bulk_ep_in_tvalid_o      (ep_tvalid),
    .bulk_ep_in_tready_i      (ep_tready),
    .bulk_ep_in_tlast_o       (ep_tlast),
    .bulk_ep_in_tdata_o       (ep_tdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int s);
    return 8'((s * 37) ^ (s >> 8) ^ 90);
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops one expected {tlast,data} per accepted beat, checks stall stability.
  initial begin
    logic       held;
    logic [8:0] held_w;
    held = 1'b0;
    held_w = '0;
    forever begin
      @(negedge clk);
      if (ep_tvalid) begin
        if (held) check("stall_stable", 32'({ep_tlast, ep_tdata}), 32'(held_w));
        if (ep_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected no beat", {ep_tlast, ep_tdata});
          end else begin
            check("beat", 32'({ep_tlast, ep_tdata}), 32'(exp_q.pop_front()));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_w = {ep_tlast, ep_tdata};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Drives n bytes; stops early if tready stays low for max_idle cycles.
  task automatic write_stream(input int n, input bit last_end, input int max_idle, output int accepted);
    int idle;
    bit bnd;
    accepted = 0;
    for (int i = 0; i < n; i++) begin
      axis_tvalid = 1'b1;
      axis_tdata  = pat(wr_seq);
      axis_tlast  = last_end && (i == n - 1);
      idle = 0;
      @(negedge clk);
      while (!axis_tready && idle < max_idle) begin
        @(negedge clk);
        idle++;
      end
      if (!axis_tready) break;
      @(posedge clk);
      #1;
      bnd = axis_tlast || (model_wr_cnt == MAXP - 1);
      buf_q.push_back({bnd, axis_tdata});
      model_wr_cnt = bnd ? 0 : model_wr_cnt + 1;
      wr_seq++;
      accepted++;
    end
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
  endtask

  // Starts an IN transaction and consumes beats up to tlast, or stop_after beats.
  task automatic read_pkt(input int stop_after, input bit stall);
    int beats, guard, len;
    bit done;
    len = 0;
    while (len < buf_q.size() - 1 && !buf_q[len][8]) len++;
    len++;
    for (int i = 0; i < len; i++)
      if (stop_after == 0 || i < stop_after) exp_q.push_back(buf_q[i]);
    xfer = 1'b1;
    @(posedge clk);
    #1;
    xfer = 1'b0;
    beats = 0;
    done = 1'b0;
    guard = 0;
    while (!done && guard < 4000) begin
      ep_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (ep_tvalid && ep_tready) begin
        beats++;
        if (ep_tlast || beats == stop_after) done = 1'b1;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    ep_tready = 1'b0;
    check("read_done", 32'(done), 32'd1);
  endtask

  task automatic ack_pkt();
    logic [8:0] w;
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    do w = buf_q.pop_front(); while (!w[8] && buf_q.size() != 0);
  endtask

  task automatic abort_pkt();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic xfer_ignored(input string name);
    bit seen;
    seen = 1'b0;
    xfer = 1'b1;
    @(posedge clk);
    #1;
    xfer = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ep_tvalid) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    cycles(3);
    check("rst_axis_tready", 32'(axis_tready), 32'd0);
    check("rst_ready_write", 32'(ready_write), 32'd0);
    check("rst_tvalid", 32'(ep_tvalid), 32'd0);
    check("rst_tlast", 32'(ep_tlast), 32'd0);
    check("rst_tdata", 32'(ep_tdata), 32'd0);
    reset_n = 1'b1;
    cycles(2);
    check("axis_tready_after_rst", 32'(axis_tready), 32'd1);
    xfer_ignored("xfer_empty_ignored");

    // 1: 4-byte transfer with tlast
    write_stream(4, 1'b1, 50, acc);
    check("t1_accepted", 32'(acc), 32'd4);
    cycles(2);
    check("t1_ready_write", 32'(ready_write), 32'd1);
    read_pkt(0, 1'b0);
    cycles(1);
    check("t1_ready_write_in_flight", 32'(ready_write), 32'd0);
    ack_pkt();
    cycles(1);
    check("t1_ready_write_after_ack", 32'(ready_write), 32'd0);

    // 2: 1025 bytes -> 512, 512, 1
    write_stream(1025, 1'b1, 50, acc);
    check("t2_accepted", 32'(acc), 32'd1025);
    cycles(2);
    for (int p = 0; p < 3; p++) begin
      check("t2_ready_write", 32'(ready_write), 32'd1);
      read_pkt(0, 1'b0);
      ack_pkt();
      cycles(1);
    end
    check("t2_ready_write_drained", 32'(ready_write), 32'd0);

    // 3: abort after 100 beats, resend from byte 0
    write_stream(512, 1'b1, 50, acc);
    check("t3_accepted", 32'(acc), 32'd512);
    cycles(2);
    read_pkt(100, 1'b0);
    abort_pkt();
    cycles(1);
    check("t3_ready_write_after_abort", 32'(ready_write), 32'd1);
    read_pkt(0, 1'b0);
    ack_pkt();
    cycles(1);
    check("t3_ready_write_after_ack", 32'(ready_write), 32'd0);

    // 4: fill buffer, one ack frees exactly one packet of space
    write_stream(2100, 1'b0, 20, acc);
    check("t4_fill_count", 32'(acc), 32'd2048);
    check("t4_tready_full", 32'(axis_tready), 32'd0);
    read_pkt(0, 1'b0);
    ack_pkt();
    cycles(1);
    check("t4_tready_after_ack", 32'(axis_tready), 32'd1);
    write_stream(600, 1'b0, 20, acc);
    check("t4_refill_count", 32'(acc), 32'd512);
    check("t4_tready_full_again", 32'(axis_tready), 32'd0);

    // 5: drain remaining four packets with random core stalls
    for (int p = 0; p < 4; p++) begin
      read_pkt(0, 1'b1);
      ack_pkt();
      cycles(1);
    end
    check("t5_ready_write_drained", 32'(ready_write), 32'd0);
    check("t5_tready_empty", 32'(axis_tready), 32'd1);

    // 6: reset mid-SEND with two packets pending
    write_stream(10, 1'b1, 50, acc);
    write_stream(20, 1'b1, 50, acc);
    cycles(2);
    check("t6_ready_write", 32'(ready_write), 32'd1);
    read_pkt(3, 1'b0);
    check("t6_tvalid_mid_send", 32'(ep_tvalid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(ep_tvalid), 32'd0);
    check("t6_rst_tlast", 32'(ep_tlast), 32'd0);
    check("t6_rst_tdata", 32'(ep_tdata), 32'd0);
    check("t6_rst_axis_tready", 32'(axis_tready), 32'd0);
    check("t6_rst_ready_write", 32'(ready_write), 32'd0);
    exp_q.delete();
    buf_q.delete();
    model_wr_cnt = 0;
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
    check("t6_ready_write_after_rst", 32'(ready_write), 32'd0);
    check("t6_axis_tready_after_rst", 32'(axis_tready), 32'd1);
    xfer_ignored("t6_buffer_empty");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
